imem_responder: RTL and testbench

- Multi-cycle instruction-memory responder: the memory side of the fetch interface.
- The fetch stage presents a 16-bit byte address with a read strobe.
- The block answers after a programmable latency with a one-cycle done pulse and the instruction word, and holds stall high while the access is in flight.
- A flush input (branch redirect) abandons an in-flight access. A side load port lets the bench or boot logic preload program words.

---
 rtl/imem_responder.sv | 104 ++++++++++
 tb/tb_imem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Multi-cycle instruction-memory responder: answers a fetch read after LATENCY edges
// with a one-cycle done pulse, holding stall while the access is in flight.
module imem_responder #(
   parameter int LATENCY = 3,
   parameter int AW      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rd,
   input  logic [15:0] addr,
   input  logic        flush,
   input  logic        ld_en,
   input  logic [15:0] ld_addr,
   input  logic [15:0] ld_data,
   output logic [15:0] data_out,
   output logic        done,
   output logic        stall,
   output logic        err,
   output logic [1:0]  stateDbg
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
   localparam logic [15:0] NOP_WORD = 16'h0800;

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic [15:0]   addrL;
   logic          errQ;
   logic [15:0]   mem [0:(1 << AW) - 1];

   logic          accept;
   logic          enterResp;
   logic [AW-1:0] respIdx;
   logic          respErr;
   logic [AW-1:0] ldIdx;

   // A request can be taken from IDLE or, back-to-back, from RESP; flush always wins.
   assign accept = rd & ~flush & (state != WAIT);

   assign enterResp = ((state == WAIT) & ~flush & (cnt == 4'd0)) |
                      (accept & (LATENCY == 1));

   // With LATENCY=1 the response is loaded on the accepting edge, before addrL holds it.
   assign respIdx = (state == WAIT) ? AW'(addrL >> 1) : AW'(addr >> 1);
   assign respErr = (state == WAIT) ? addrL[0] : addr[0];
   assign ldIdx   = AW'(ld_addr >> 1);

   assign done     = (state == RESP) & ~flush;
   assign err      = errQ & done;
   assign stall    = (state == WAIT) | (rd & ~flush & (state != WAIT));
   assign stateDbg = state;

   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ldIdx] <= ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         addrL    <= 16'h0000;
         data_out <= 16'h0000;
         errQ     <= 1'b0;
      end else begin
         case (state)
            WAIT: begin
               if (flush) begin
                  state <= IDLE;
               end else if (cnt == 4'd0) begin
                  state <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               if (accept) begin
                  addrL <= addr;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase

         // The array read here sees writes from earlier edges only, not this one.
         if (enterResp) begin
            data_out <= respErr ? NOP_WORD : mem[respIdx];
            errQ     <= respErr;
         end
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (LATENCY=3, AW=8): hand-computed vectors
// checked with immediate assertions at each comparison point.
module tb_imem_responder;

   logic        clk;
   logic        rst;
   logic        rd;
   logic [15:0] addr;
   logic        flush;
   logic        ld_en;
   logic [15:0] ld_addr;
   logic [15:0] ld_data;
   logic [15:0] data_out;
   logic        done;
   logic        stall;
   logic        err;
   logic [1:0]  stateDbg;

   int errors = 0;
   int checks = 0;

   imem_responder #(.LATENCY(3), .AW(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .rd       (rd),
      .addr     (addr),
      .flush    (flush),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .data_out (data_out),
      .done     (done),
      .stall    (stall),
      .err      (err),
      .stateDbg (stateDbg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic preload(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      ld_en   = 1'b1;
      ld_addr = a;
      ld_data = d;
      @(negedge clk);
      ld_en   = 1'b0;
   endtask

   // Request at the current negedge; done expected three cycles later.
   task automatic simpleRead(input string tag, input logic [15:0] a,
                             input logic [15:0] expD, input logic expE);
      @(negedge clk);
      rd = 1'b1; addr = a;
      #1 check({tag, "_stall0"}, 16'(stall), 16'd1);
      check({tag, "_done0"}, 16'(done), 16'd0);
      @(negedge clk);
      rd = 1'b0;
      #1 check({tag, "_stall1"}, 16'(stall), 16'd1);
      check({tag, "_done1"}, 16'(done), 16'd0);
      @(negedge clk);
      #1 check({tag, "_stall2"}, 16'(stall), 16'd1);
      check({tag, "_done2"}, 16'(done), 16'd0);
      @(negedge clk);
      #1 check({tag, "_done"}, 16'(done), 16'd1);
      check({tag, "_data"}, data_out, expD);
      check({tag, "_err"}, 16'(err), 16'(expE));
      check({tag, "_stall3"}, 16'(stall), 16'd0);
   endtask

   initial begin
      rst = 1'b1; rd = 1'b0; addr = 16'h0; flush = 1'b0;
      ld_en = 1'b0; ld_addr = 16'h0; ld_data = 16'h0;

      // Asynchronous reset asserted mid-cycle, before any clock edge.
      #3 rst = 1'b0;
      #1 check("rst_data", data_out, 16'h0000);
      check("rst_done", 16'(done), 16'd0);
      check("rst_err", 16'(err), 16'd0);
      check("rst_stall", 16'(stall), 16'd0);
      check("rst_state", 16'(stateDbg), 16'd0);
      @(negedge clk);
      rst = 1'b1;

      preload(16'h0010, 16'h1234);
      preload(16'h0012, 16'h5678);
      preload(16'h0202, 16'hBEEF);
      preload(16'h0004, 16'h1111);

      // First read, then data_out must hold after the pulse.
      simpleRead("rd1", 16'h0010, 16'h1234, 1'b0);
      @(negedge clk);
      #1 check("hold_done", 16'(done), 16'd0);
      check("hold_data", data_out, 16'h1234);

      // Back-to-back: second request accepted in the done cycle.
      @(negedge clk);
      rd = 1'b1; addr = 16'h0010;
      #1 check("b2b_stall0", 16'(stall), 16'd1);
      @(negedge clk);
      #1 check("b2b_done1", 16'(done), 16'd0);
      @(negedge clk);
      #1 check("b2b_done2", 16'(done), 16'd0);
      @(negedge clk);
      addr = 16'h0012;
      #1 check("b2b_doneA", 16'(done), 16'd1);
      check("b2b_dataA", data_out, 16'h1234);
      check("b2b_stallA", 16'(stall), 16'd1);
      @(negedge clk);
      #1 check("b2b_done4", 16'(done), 16'd0);
      check("b2b_stall4", 16'(stall), 16'd1);
      check("b2b_state4", 16'(stateDbg), 16'd1);
      @(negedge clk);
      #1 check("b2b_done5", 16'(done), 16'd0);
      @(negedge clk);
      rd = 1'b0;
      #1 check("b2b_doneB", 16'(done), 16'd1);
      check("b2b_dataB", data_out, 16'h5678);
      check("b2b_stallB", 16'(stall), 16'd0);
      @(negedge clk);
      #1 check("b2b_done7", 16'(done), 16'd0);

      // Flush during WAIT drops the first access entirely.
      @(negedge clk);
      rd = 1'b1; addr = 16'h0010;
      @(negedge clk);
      rd = 1'b0; flush = 1'b1;
      #1 check("fl_done1", 16'(done), 16'd0);
      check("fl_stall1", 16'(stall), 16'd1);
      @(negedge clk);
      flush = 1'b0; rd = 1'b1; addr = 16'h0012;
      #1 check("fl_state2", 16'(stateDbg), 16'd0);
      check("fl_stall2", 16'(stall), 16'd1);
      @(negedge clk);
      rd = 1'b0;
      #1 check("fl_done3", 16'(done), 16'd0);
      @(negedge clk);
      #1 check("fl_done4", 16'(done), 16'd0);
      @(negedge clk);
      #1 check("fl_done5", 16'(done), 16'd1);
      check("fl_data5", data_out, 16'h5678);

      // Unaligned request returns NOP with err.
      simpleRead("unal", 16'h0011, 16'h0800, 1'b1);

      // Flush in the response cycle suppresses done and err.
      @(negedge clk);
      rd = 1'b1; addr = 16'h0013;
      @(negedge clk);
      rd = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      #1 check("flr_done", 16'(done), 16'd0);
      check("flr_err", 16'(err), 16'd0);
      @(negedge clk);
      flush = 1'b0;
      #1 check("flr_state", 16'(stateDbg), 16'd0);

      // 0x0202 aliases index 1, same as 0x0002.
      simpleRead("wrap", 16'h0002, 16'hBEEF, 1'b0);

      // Write during WAIT is visible; write on the RESP-entry edge is not.
      @(negedge clk);
      rd = 1'b1; addr = 16'h0004;
      @(negedge clk);
      rd = 1'b0; ld_en = 1'b1; ld_addr = 16'h0004; ld_data = 16'h2222;
      @(negedge clk);
      ld_data = 16'h3333;
      @(negedge clk);
      ld_en = 1'b0;
      #1 check("late_done", 16'(done), 16'd1);
      check("late_data", data_out, 16'h2222);
      simpleRead("late2", 16'h0004, 16'h3333, 1'b0);

      // Reset during WAIT drops the access at once; array contents survive.
      @(negedge clk);
      rd = 1'b1; addr = 16'h0010;
      @(negedge clk);
      rd = 1'b0;
      #2 rst = 1'b0;
      #1 check("mrst_done", 16'(done), 16'd0);
      check("mrst_stall", 16'(stall), 16'd0);
      check("mrst_data", data_out, 16'h0000);
      check("mrst_state", 16'(stateDbg), 16'd0);
      @(negedge clk);
      #1 check("mrst_done2", 16'(done), 16'd0);
      rst = 1'b1;
      simpleRead("post", 16'h0010, 16'h1234, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
